// File: rtl/smem_pkg.sv
// rtl/smem_pkg.sv - shared widths, request record and FSM states for the shared-memory core port
package smem_pkg;

    localparam int ADDR_W  = 12;
    localparam int BANK_W  = 4;
    localparam int OFS_W   = 8;
    localparam int DATA_W  = 8;
    localparam int N_BANKS = 16;
    localparam int REQ_W   = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        GAP
    } state_t;

    // One queued core request: {we, addr, wdata}
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/smem_req_fifo.sv
// rtl/smem_req_fifo.sv - synchronous request FIFO of {we, addr, wdata}
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   push, push_data       write one entry (ignored when full)
//   pop, pop_data         remove head entry (ignored when empty); pop_data shows the head
//   full, empty           derived from registered pointers
module smem_req_fifo
    import smem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    req_t           store [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = store[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            store[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/smem_core_port.sv
// rtl/smem_core_port.sv - core-side initiator that queues loads/stores and drives the 16 bank arbiters
// Ports:
//   clock, reset_n                      clock and asynchronous active-low reset
//   req_valid/req_ready/req_we/         core request handshake; addr[11:8] = bank, [7:0] = word
//   req_addr/req_wdata
//   resp_valid/resp_rdata/resp_err      one-cycle response pulse, load data (0 for stores), timeout flag
//   mem_read/mem_write/mem_addr/        this core's request lines towards every bank arbiter
//   mem_wdata
//   bank_finish/bank_rdata              per-bank finish bit and 8-bit read lane for this core
module smem_core_port
    import smem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [N_BANKS-1:0]        bank_finish,
    input  logic [N_BANKS*DATA_W-1:0] bank_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value during the last ISSUE cycle before the abort.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              state;
    state_t              state_next;
    req_t                head;
    req_t                in_req;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                issue_we;
    logic [CNT_W-1:0]    cnt;
    logic                timeout_hit;
    logic [BANK_W-1:0]   bank;
    logic                finish_sel;
    logic [DATA_W-1:0]   lane_sel;
    logic [DATA_W-1:0]   lanes [N_BANKS];

    // Gated by reset_n so the core sees "not ready" while reset is held.
    assign req_ready = reset_n && !full;
    assign push      = req_valid && req_ready;
    assign in_req    = '{we: req_we, addr: req_addr, wdata: req_wdata};

    smem_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // Only the addressed bank's finish bit and read lane matter.
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            lanes[b] = bank_rdata[b*DATA_W +: DATA_W];
        end
    end

    assign bank        = mem_addr[ADDR_W-1 -: BANK_W];
    assign finish_sel  = bank_finish[bank];
    assign lane_sel    = lanes[bank];
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // Request levels are decoded from the registered state, so an async reset
    // drops them immediately.
    assign mem_read   = (state == ISSUE) && !issue_we;
    assign mem_write  = (state == ISSUE) && issue_we;
    assign resp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (finish_sel || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            issue_we   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                issue_we  <= head.we;
                mem_addr  <= head.addr;
                mem_wdata <= head.wdata;
                cnt       <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
            end
            // Finish has priority over a timeout landing on the same edge.
            if (state == ISSUE) begin
                if (finish_sel) begin
                    resp_rdata <= issue_we ? '0 : lane_sel;
                    resp_err   <= 1'b0;
                end else if (timeout_hit) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_smem_core_port.sv
// tb/tb_smem_core_port.sv - scoreboard bench for smem_core_port with a randomized bank responder
module tb_smem_core_port;

    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [11:0]  req_addr = '0;
    logic [7:0]   req_wdata = '0;
    logic         resp_valid;
    logic [7:0]   resp_rdata;
    logic         resp_err;
    logic         mem_read;
    logic         mem_write;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [15:0]  bank_finish = '0;
    logic [127:0] bank_rdata = '0;

    smem_core_port #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .bank_finish (bank_finish),
        .bank_rdata  (bank_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        int          d;      // ISSUE cycles with finish low before finish rises
        logic [7:0]  lane;
    } plan_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    bit    aborted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: the request succeeds if finish lands within the first TO ISSUE cycles.
    function automatic bit finishes(input int d);
        return (d + 1) <= TO;
    endfunction

    task automatic send(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                        input int d, input logic [7:0] lane);
        int    n;
        plan_t p;
        exp_t  e;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            fail("send_accept");
            req_valid = 1'b0;
            return;
        end
        p = '{we: we, addr: addr, wdata: wdata, d: d, lane: lane};
        e.rdata = (finishes(d) && !we) ? lane : 8'h00;
        e.err   = !finishes(d);
        plan_q.push_back(p);
        exp_q.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || plan_q.size() > 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() > 0 || plan_q.size() > 0) fail("drain");
        repeat (3) @(negedge clock);
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    initial begin
        bit   prev_mem;
        bit   prev_resp;
        exp_t e;
        prev_mem  = 1'b0;
        prev_resp = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (prev_resp) check("gap_after_resp", {31'd0, mem_read | mem_write}, 32'd0);
                if (resp_valid) begin
                    check("resp_follows_issue", {31'd0, prev_mem}, 32'd1);
                    if (exp_q.size() == 0) begin
                        fail("unexpected_resp");
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata", {24'd0, resp_rdata}, {24'd0, e.rdata});
                        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    end
                end
                prev_mem  = mem_read | mem_write;
                prev_resp = resp_valid;
            end else begin
                prev_mem  = 1'b0;
                prev_resp = 1'b0;
            end
        end
    end

    // Bank responder: plays the arbiter for each issued request, adds stray and wrong-bank finishes.
    initial begin
        plan_t       p;
        int          i;
        int          bk;
        logic [15:0] own;
        forever begin
            @(negedge clock);
            if (reset_n && (mem_read || mem_write)) begin
                if (plan_q.size() == 0) begin
                    fail("unplanned_issue");
                end else begin
                    p   = plan_q.pop_front();
                    bk  = int'(p.addr[11:8]);
                    own = 16'(1) << bk;
                    i   = 0;
                    while ((mem_read || mem_write) && i < 64) begin
                        i++;
                        check("issue_rw", {30'd0, mem_write, mem_read}, p.we ? 32'd2 : 32'd1);
                        check("issue_addr", {20'd0, mem_addr}, {20'd0, p.addr});
                        check("issue_wdata", {24'd0, mem_wdata}, {24'd0, p.wdata});
                        bank_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
                        bank_finish = (16'($urandom()) | 16'h0004) & ~own;
                        if (i == p.d + 1) begin
                            bank_finish = bank_finish | own;
                            bank_rdata[bk*8 +: 8] = p.lane;
                        end
                        @(negedge clock);
                    end
                    if (!aborted) begin
                        check("issue_cycles", i, finishes(p.d) ? p.d + 1 : TO);
                    end
                end
            end
            bank_finish = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'h0000;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;

        // Reset state
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_resp", {22'd0, resp_valid, resp_err, resp_rdata}, 32'd0);
        check("rst_mem_addr", {12'd0, mem_addr, mem_wdata}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Load: bank 3 finishes 4 cycles after mem_read; also checks issue latency
        send(1'b0, 12'h3A5, 8'h00, 4, 8'h5C);
        @(negedge clock);
        check("lat_idle_cycle", {31'd0, mem_read}, 32'd0);
        @(negedge clock);
        check("lat_issue_cycle", {31'd0, mem_read}, 32'd1);
        drain();

        // Store to bank 15
        send(1'b1, 12'hF00, 8'h7E, 2, 8'hAA);
        drain();

        // Wrong-bank finish (bank 2 always toggled) while bank 5 pending
        send(1'b0, 12'h512, 8'h00, 5, 8'hC3);
        drain();

        // Timeout and finish-on-timeout-edge
        send(1'b0, 12'h7F0, 8'h00, 10, 8'h11);
        send(1'b0, 12'h701, 8'h00, TO - 1, 8'h99);
        send(1'b1, 12'h0FF, 8'h42, TO, 8'h00);
        drain();

        // Fill the queue behind a busy ISSUE
        send(1'b0, 12'h123, 8'h00, 7, 8'hA1);
        n = 0;
        while (!(mem_read || mem_write) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!(mem_read || mem_write)) fail("fill_issue_start");
        send(1'b1, 12'h234, 8'h01, 1, 8'h00);
        send(1'b0, 12'h345, 8'h00, 0, 8'hB2);
        send(1'b0, 12'h456, 8'h00, 3, 8'hB3);
        send(1'b1, 12'h567, 8'h04, 6, 8'h00);
        check("fill_ready_low", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("fill_ready_back", {31'd0, req_ready}, 32'd1);
        drain();

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            send(1'($urandom()), 12'($urandom()), 8'($urandom()),
                 $urandom_range(0, 10), 8'($urandom()));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();

        // Reset mid-ISSUE with requests still queued
        send(1'b0, 12'h4AA, 8'h00, 20, 8'h00);
        n = 0;
        while (!mem_read && n < 50) begin
            @(negedge clock);
            n++;
        end
        send(1'b0, 12'h111, 8'h00, 0, 8'h01);
        send(1'b1, 12'h222, 8'h02, 0, 8'h00);
        send(1'b0, 12'h333, 8'h00, 0, 8'h03);
        @(posedge clock);
        #2;
        check("pre_reset_in_issue", {31'd0, mem_read}, 32'd1);
        aborted = 1'b1;
        reset_n = 1'b0;
        #1;
        check("async_rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("async_rst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(negedge clock);
        plan_q.delete();
        exp_q.delete();
        reset_n = 1'b1;
        aborted = 1'b0;
        #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        hi = 0;
        repeat (20) begin
            @(negedge clock);
            if (mem_read || mem_write || resp_valid) hi++;
        end
        check("post_rst_queue_empty", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
